// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator and checker: FSM encoding
// and the default feedback mask for the 4-bit polynomial x^4+x^3+1.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] TAPS_W4 = 4'b1100;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR step: left shift with XOR feedback into bit 0.
// Shared by generator and checker so both ends use one polynomial.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W4)
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    assign o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to an incoming state stream,
// then flags every word that disagrees with the locally predicted next state.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TAPS_W4),
    parameter int               LOCK_CNT   = 3,
    parameter int               ERR_THRESH = 4,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Valid-only stream: a word is consumed on every rising edge with
    // in_valid=1; there is no ready, so the checker never stalls the source.
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       o_dbg_state
);

    state_t           r_state;
    logic [WIDTH-1:0] r_ref;
    logic [7:0]       r_match_cnt;
    logic [7:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_ref_nxt;
    logic [7:0]       w_match_nxt;
    logic [7:0]       w_miss_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_pred;
    logic             w_hit;
    logic             w_nonzero;
    logic [7:0]       w_match_inc;
    logic [7:0]       w_miss_inc;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_nxt;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .i_state (r_ref),
        .o_next  (w_pred)
    );

    assign w_hit       = (in_data == w_pred);
    assign w_nonzero   = |in_data;
    assign w_match_inc = r_match_cnt + 8'd1;
    assign w_miss_inc  = r_miss_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_nxt   = 1'b0;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    // All-zero is the LFSR lockup word and cannot seed a sequence.
                    if (w_nonzero) begin
                        w_ref_nxt   = in_data;
                        w_match_nxt = 8'd0;
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        w_ref_nxt   = in_data;
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == 8'(LOCK_CNT)) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = 8'd0;
                        end
                    end else if (w_nonzero) begin
                        w_ref_nxt   = in_data;
                        w_match_nxt = 8'd0;
                    end else begin
                        w_state_nxt = SEARCH;
                    end
                end
                LOCKED: begin
                    if (w_hit) begin
                        w_ref_nxt  = in_data;
                        w_miss_nxt = 8'd0;
                    end else begin
                        // Flywheel: keep the predicted sequence, drop the bad word.
                        w_ref_nxt  = w_pred;
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == 8'(ERR_THRESH)) begin
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                end
            endcase
        end
    end

    // Clear first, then count, so a simultaneous clear and error leaves 1.
    assign w_cnt_base = clear_cnt ? '0 : r_err_cnt;
    assign w_cnt_nxt  = (w_err_nxt && !(&w_cnt_base)) ? w_cnt_base + CNT_W'(1) : w_cnt_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SEARCH;
            r_ref       <= '0;
            r_match_cnt <= 8'd0;
            r_miss_cnt  <= 8'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err       <= w_err_nxt;
            r_err_cnt   <= w_cnt_nxt;
        end
    end

    assign locked      = r_locked;
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: a sequence-table reference model
// predicts lock, error pulses and both a 16-bit and a 2-bit saturating count.
module tb_lfsr_checker;

    localparam int         LOCK_CNT   = 3;
    localparam int         ERR_THRESH = 4;
    localparam logic [3:0] TB_TAPS    = 4'b1100;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        in_valid  = 1'b0;
    logic [3:0]  in_data   = 4'd0;
    logic        clear_cnt = 1'b0;
    logic        locked, err, locked_s, err_s;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt_s;
    logic [1:0]  dbg_state, dbg_state_s;

    always #5 clk = ~clk;

    lfsr_checker #(.WIDTH(4), .TAPS(TB_TAPS), .LOCK_CNT(LOCK_CNT),
                   .ERR_THRESH(ERR_THRESH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(locked), .err(err),
        .err_cnt(err_cnt), .o_dbg_state(dbg_state));

    lfsr_checker #(.WIDTH(4), .TAPS(TB_TAPS), .LOCK_CNT(LOCK_CNT),
                   .ERR_THRESH(ERR_THRESH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(locked_s), .err(err_s),
        .err_cnt(err_cnt_s), .o_dbg_state(dbg_state_s));

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {locked, err, err_cnt[15:0], err_cnt_sat[1:0], state[1:0]}.
    logic [21:0] exp_q[$];

    // The maximal sequence as a table; prediction is "the entry after this one".
    logic [3:0] seq[15];
    int         pos[16];

    bit         m_sync, m_locked, m_err;
    logic [3:0] m_ref;
    int         m_streak, m_misses, m_cnt16, m_cnt2;

    function automatic logic [3:0] predict(logic [3:0] s);
        if (s == 4'd0) return 4'd0;
        return seq[(pos[s] + 1) % 15];
    endfunction

    function automatic logic [3:0] wrong_word(logic [3:0] good);
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        if (w == good) w = w ^ 4'($urandom_range(1, 15));
        return w;
    endfunction

    function automatic logic [21:0] observed();
        return {locked, err, err_cnt, err_cnt_s, dbg_state};
    endfunction

    task automatic build_table();
        logic [3:0] s;
        s = 4'd1;
        for (int i = 0; i < 15; i++) begin
            seq[i] = s;
            pos[s] = i;
            s = 4'((int'(s) * 2) % 16 + ($countones(s & TB_TAPS) % 2));
        end
    endtask

    task automatic model_clear();
        m_sync = 0; m_locked = 0; m_err = 0; m_ref = 4'd0;
        m_streak = 0; m_misses = 0; m_cnt16 = 0; m_cnt2 = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; clear_cnt = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [3:0] d, input bit c);
        logic [3:0] pred;
        logic [1:0] st;
        in_valid = v; in_data = d; clear_cnt = c;
        m_err = 0;
        if (v) begin
            pred = predict(m_ref);
            if (!m_sync) begin
                if (d != 4'd0) begin m_ref = d; m_streak = 0; m_sync = 1; end
            end else if (!m_locked) begin
                if (d == pred) begin
                    m_ref = d; m_streak++;
                    if (m_streak == LOCK_CNT) begin m_locked = 1; m_misses = 0; end
                end else if (d != 4'd0) begin
                    m_ref = d; m_streak = 0;
                end else begin
                    m_sync = 0;
                end
            end else begin
                if (d == pred) begin
                    m_ref = d; m_misses = 0;
                end else begin
                    m_ref = pred; m_err = 1; m_misses++;
                    if (m_misses == ERR_THRESH) begin m_locked = 0; m_sync = 0; end
                end
            end
        end
        if (c) begin m_cnt16 = 0; m_cnt2 = 0; end
        if (m_err) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        st = m_locked ? 2'd2 : (m_sync ? 2'd1 : 2'd0);
        @(posedge clk);
        #1;
        exp_q.push_back({m_locked, m_err, 16'(m_cnt16), 2'(m_cnt2), st});
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst = 1'b0; in_valid = 1'b1; in_data = 4'b1111;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        obs = observed();
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, 22'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquire();
        logic [3:0]  words[4];
        logic [21:0] exp, obs;
        words = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 1'b0);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL acquire word %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL acquire_locked: locked=%b err=%b expected locked=1 err=0", locked, err);
        end
    endtask

    task automatic test_single_error();
        logic [3:0]  words[3];
        logic [21:0] exp, obs;
        words = '{4'b0101, 4'b0010, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, words[i], 1'b0);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_error word %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_error_count: err_cnt=%0d locked=%b expected 1 and 1", err_cnt, locked);
        end
    endtask

    task automatic test_lock_loss();
        logic [21:0] exp, obs;
        logic [3:0]  s;
        int          base;
        base = m_cnt16;
        for (int i = 0; i < ERR_THRESH; i++) begin
            drive(1'b1, wrong_word(predict(m_ref)), 1'b0);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lock_loss miss %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (err_cnt !== 16'(base + ERR_THRESH) || locked !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL lock_loss_final: err_cnt=%0d locked=%b err=%b expected %0d 0 1",
                     err_cnt, locked, err, base + ERR_THRESH);
        end
        s = 4'($urandom_range(1, 15));
        for (int i = 0; i <= LOCK_CNT; i++) begin
            drive(1'b1, s, 1'b0);
            s = predict(s);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL relock word %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_locked: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_zero_gaps();
        logic [21:0] exp, obs;
        logic [3:0]  s;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'd0, 1'b0);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_search word %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (dbg_state !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL zero_stays_search: state=%0d locked=%b expected 0 0", dbg_state, locked);
        end
        s = 4'($urandom_range(1, 15));
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 3)) begin
                drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
                exp = exp_q.pop_front(); obs = observed();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL gap before word %0d: got %h expected %h", i, obs, exp);
                end
            end
            drive(1'b1, s, 1'b0);
            s = predict(s);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL gapped word %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (err_cnt !== 16'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL gaps_no_errors: err_cnt=%0d locked=%b expected 0 1", err_cnt, locked);
        end
    endtask

    task automatic test_saturation();
        logic [21:0] exp, obs;
        int          base;
        base = m_cnt16;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, wrong_word(predict(m_ref)), 1'b0);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL saturate bad %0d: got %h expected %h", i, obs, exp);
            end
            drive(1'b1, predict(m_ref), 1'b0);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL saturate good %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (err_cnt_s !== 2'd3 || err_cnt !== 16'(base + 5)) begin
            errors++;
            $display("FAIL saturate_final: narrow=%0d wide=%0d expected 3 %0d", err_cnt_s, err_cnt, base + 5);
        end
    endtask

    task automatic test_clear_with_err();
        logic [21:0] exp, obs;
        drive(1'b1, wrong_word(predict(m_ref)), 1'b1);
        exp = exp_q.pop_front(); obs = observed();
        checks++;
        if (obs !== exp || err_cnt !== 16'd1 || err_cnt_s !== 2'd1) begin
            errors++;
            $display("FAIL clear_and_err: got %h expected %h (counts must be 1)", obs, exp);
        end
        drive(1'b1, predict(m_ref), 1'b1);
        exp = exp_q.pop_front(); obs = observed();
        checks++;
        if (obs !== exp || err_cnt !== 16'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clear_only: got %h expected %h (count 0, still locked)", obs, exp);
        end
    endtask

    task automatic test_random();
        logic [21:0] exp, obs;
        logic [3:0]  d;
        bit          v, c;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            d = ($urandom_range(0, 3) != 0) ? predict(m_ref) : 4'($urandom_range(0, 15));
            drive(v, d, c);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] exp, obs;
        logic [3:0]  s;
        do_reset();
        s = 4'($urandom_range(1, 15));
        for (int i = 0; i <= LOCK_CNT; i++) begin
            drive(1'b1, s, 1'b0);
            s = predict(s);
            void'(exp_q.pop_front());
        end
        drive(1'b1, wrong_word(predict(m_ref)), 1'b0);
        exp = exp_q.pop_front(); obs = observed();
        checks++;
        if (obs !== exp || err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_error: got %h expected %h", obs, exp);
        end
        #2 rst = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, 22'd0);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        s = 4'($urandom_range(1, 15));
        for (int i = 0; i <= LOCK_CNT; i++) begin
            drive(1'b1, s, 1'b0);
            s = predict(s);
            exp = exp_q.pop_front(); obs = observed();
            checks++;
            if (obs !== exp || locked !== (i == LOCK_CNT)) begin
                errors++;
                $display("FAIL relock_after_reset word %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_acquire();
        test_single_error();
        test_lock_loss();
        test_zero_gaps();
        test_saturation();
        test_clear_with_err();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
